// File: rtl/ins_ram_pkg.sv
// Shared definitions for the instruction-memory responder and the CPU datapath.
`default_nettype none

package ins_ram_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_array_sp.sv
// 2**AW x WORD_W instruction array: synchronous write, registered read.
`default_nettype none

module ram_array_sp
  import ins_ram_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_nop,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**AW];

  // Contents are deliberately left out of reset so a preloaded program survives it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read and same-edge write both sample old contents, so a colliding write is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= NOP_WORD;
    end else if (rd_en) begin
      rd_data <= rd_nop ? NOP_WORD : mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ins_ram_responder.sv
// Memory end of the CPU fetch handshake: fixed-latency read with one-cycle response strobe.
`default_nettype none

module ins_ram_responder
  import ins_ram_pkg::*;
#(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] ins,
  output logic              en_ram_out,
  output logic              addr_err,
  output logic              busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data
);

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_addr;
  logic          lat_oob;
  logic          rd_en;

  // The array read happens on the same edge that enters RESP, so ins lands with the strobe.
  assign rd_en = (state == ST_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lat_addr   <= '0;
      lat_oob    <= 1'b0;
      en_ram_out <= 1'b0;
      addr_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          en_ram_out <= 1'b0;
          addr_err   <= 1'b0;
          if (en_ram_in) begin
            lat_addr <= addr[AW-1:0];
            lat_oob  <= |addr[WORD_W-1:AW];
            cnt      <= 4'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // cnt counts remaining edges before the RESP-entry edge (zero for LATENCY=1).
          if (cnt == 4'd0) begin
            en_ram_out <= 1'b1;
            addr_err   <= lat_oob;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          en_ram_out <= 1'b0;
          addr_err   <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  ram_array_sp #(
    .AW(AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_nop  (lat_oob),
    .rd_addr (lat_addr),
    .rd_data (ins)
  );

endmodule

`default_nettype wire

// File: tb/tb_ins_ram_responder.sv
// Randomized bench: three responders (LATENCY 2, 1, 3) share stimulus and a timeline-based reference model.
`default_nettype none

module tb_ins_ram_responder;

  localparam int AW = 8;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_ram_in = 1'b0;
  logic [15:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;

  logic [15:0]   ins_o [NI];
  logic [NI-1:0] out_o;
  logic [NI-1:0] err_o;
  logic [NI-1:0] busy_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ins_ram_responder #(.AW(AW), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr),
    .ins(ins_o[0]), .en_ram_out(out_o[0]), .addr_err(err_o[0]), .busy(busy_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  ins_ram_responder #(.AW(AW), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr),
    .ins(ins_o[1]), .en_ram_out(out_o[1]), .addr_err(err_o[1]), .busy(busy_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  ins_ram_responder #(.AW(AW), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr),
    .ins(ins_o[2]), .en_ram_out(out_o[2]), .addr_err(err_o[2]), .busy(busy_o[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  // Reference model: each request is a point on an edge timeline; response at accept+L,
  // release at accept+L+1, next accept no earlier than accept+L+2.
  int unsigned lat [NI] = '{2, 1, 3};
  logic [15:0] mmem [256];
  int unsigned edge_no = 0;
  bit          m_act  [NI];
  int unsigned m_acc  [NI];
  logic [15:0] m_addr [NI];
  logic [15:0] m_ins  [NI];
  bit          m_out  [NI];
  bit          m_err  [NI];
  bit          m_busy [NI];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        m_act[k]  = 1'b0;
        m_ins[k]  = 16'h0000;
        m_out[k]  = 1'b0;
        m_err[k]  = 1'b0;
        m_busy[k] = 1'b0;
      end
    end else begin
      edge_no++;
      for (int k = 0; k < NI; k++) begin
        m_out[k] = 1'b0;
        m_err[k] = 1'b0;
        if (m_act[k] && edge_no == m_acc[k] + lat[k]) begin
          m_out[k] = 1'b1;
          if (m_addr[k] >= 16'd256) begin
            m_ins[k] = 16'h0000;
            m_err[k] = 1'b1;
          end else begin
            m_ins[k] = mmem[m_addr[k][7:0]];
          end
        end
        if (m_act[k] && edge_no == m_acc[k] + lat[k] + 1) begin
          m_act[k] = 1'b0;
        end else if (!m_act[k] && en_ram_in) begin
          m_act[k]  = 1'b1;
          m_acc[k]  = edge_no;
          m_addr[k] = addr;
        end
        m_busy[k] = m_act[k];
      end
      if (wr_en) mmem[wr_addr] = wr_data;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("ins_L%0d", lat[k]), ins_o[k], m_ins[k]);
      check($sformatf("en_ram_out_L%0d", lat[k]), 16'(out_o[k]), 16'(m_out[k]));
      check($sformatf("addr_err_L%0d", lat[k]), 16'(err_o[k]), 16'(m_err[k]));
      check($sformatf("busy_L%0d", lat[k]), 16'(busy_o[k]), 16'(m_busy[k]));
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input logic en, input logic [15:0] a,
                      input logic we, input logic [7:0] wa, input logic [15:0] wd);
    @(negedge clk);
    check_all();
    en_ram_in = en;
    addr      = a;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 8'h0, 16'h0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    check_all();
    en_ram_in = 1'b0;
    wr_en     = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_all();
    check("ins_async_clear", ins_o[0], 16'h0000);
    check("busy_async_clear", 16'(busy_o), 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      check_all();
      check("reset_out", 16'({out_o, err_o, busy_o}), 16'h0000);
    end
    rst = 1'b1;

    for (int i = 0; i < 256; i++) step(1'b0, 16'h0, 1'b1, 8'(i), 16'hA000 + 16'(i));
    step(1'b0, 16'h0, 1'b1, 8'd5, 16'h1234);
    step(1'b0, 16'h0, 1'b1, 8'd3, 16'h1111);
    step(1'b0, 16'h0, 1'b1, 8'd7, 16'hBEEF);
    idle(2);

    step(1'b1, 16'h0005, 1'b0, 8'h0, 16'h0);   // basic fetch
    idle(6);
    step(1'b1, 16'h0100, 1'b0, 8'h0, 16'h0);   // out of range
    idle(6);
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 8'h0, 16'h0);   // continuous
    idle(6);
    step(1'b1, 16'h0003, 1'b0, 8'h0, 16'h0);   // write/read collision
    step(1'b0, 16'h0003, 1'b1, 8'd3, 16'h2222);
    idle(5);
    step(1'b1, 16'h0003, 1'b0, 8'h0, 16'h0);
    idle(6);
    step(1'b1, 16'h0007, 1'b0, 8'h0, 16'h0);   // LATENCY=1 corner, held high
    step(1'b1, 16'h0008, 1'b0, 8'h0, 16'h0);
    step(1'b1, 16'h0009, 1'b0, 8'h0, 16'h0);
    idle(6);
    step(1'b1, 16'h0005, 1'b0, 8'h0, 16'h0);   // reset mid-operation
    step(1'b0, 16'h0, 1'b0, 8'h0, 16'h0);
    pulse_reset();
    step(1'b1, 16'h0007, 1'b0, 8'h0, 16'h0);
    idle(6);

    for (int i = 0; i < 600; i++) begin
      logic        en, we;
      logic [15:0] a;
      if ($urandom_range(0, 99) == 0) pulse_reset();
      en = ($urandom_range(0, 1) == 1);
      we = ($urandom_range(0, 9) < 3);
      a  = ($urandom_range(0, 4) == 0) ? (16'($urandom) | 16'h0100) : 16'($urandom_range(0, 15));
      step(en, a, we, 8'($urandom_range(0, 15)), 16'($urandom));
    end
    idle(6);
    @(negedge clk);
    check_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
